// File: rtl/twi_seq_if.sv
// rtl/twi_seq_if.sv - request/response and twi_core register port bundle for twi_seq
interface twi_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       twi_wr;
    logic [7:0] twi_addr;
    logic [7:0] twi_data;
    logic [7:0] twi_i2cr;
    logic [7:0] twi_i2rd;

    modport slave (
        input  req_valid, req_rd, req_dev, req_reg, req_wdata, twi_i2cr, twi_i2rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, twi_wr, twi_addr, twi_data
    );

    modport master (
        output req_valid, req_rd, req_dev, req_reg, req_wdata, twi_i2cr, twi_i2rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, twi_wr, twi_addr, twi_data
    );
endinterface

// File: rtl/twi_seq.sv
// rtl/twi_seq.sv - expands one I2C register request into twi_core START/WR/RD/STOP commands
// Optional done-poll timeout abort enabled by defining TWI_SEQ_TIMEOUT_EN.
module twi_seq
`ifdef TWI_SEQ_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 16384
)
`endif
(
    input  logic          clk,
    input  logic          rst,
    twi_seq_if.slave      bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDWD = 3'd1;
    localparam logic [2:0] S_KICK = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DIS  = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    localparam logic [7:0] ADDR_I2CR = 8'h00;
    localparam logic [7:0] ADDR_I2WD = 8'h01;

    localparam logic [7:0] CMD_START = 8'h03;
    localparam logic [7:0] CMD_WR    = 8'h13;
    localparam logic [7:0] CMD_RD    = 8'h23;
    localparam logic [7:0] CMD_STOP  = 8'h33;
    localparam logic [7:0] CMD_DIS   = 8'h00;

    function automatic logic [7:0] f_cmd(input logic rd, input logic [2:0] step);
        logic [7:0] c;
        c = CMD_STOP;
        if (rd) begin
            case (step)
                3'd0, 3'd3:       c = CMD_START;
                3'd1, 3'd2, 3'd4: c = CMD_WR;
                3'd5:             c = CMD_RD;
                default:          c = CMD_STOP;
            endcase
        end else begin
            case (step)
                3'd0:             c = CMD_START;
                3'd1, 3'd2, 3'd3: c = CMD_WR;
                default:          c = CMD_STOP;
            endcase
        end
        return c;
    endfunction

    // Byte loaded into I2WD for a WR step; step 3 is only a WR step on writes, step 4 only on reads.
    function automatic logic [7:0] f_byte(input logic [2:0] step, input logic [6:0] dev,
                                          input logic [7:0] ra, input logic [7:0] wd);
        logic [7:0] b;
        case (step)
            3'd1:    b = {dev, 1'b0};
            3'd2:    b = ra;
            3'd4:    b = {dev, 1'b1};
            default: b = wd;
        endcase
        return b;
    endfunction

    logic [2:0] r_state;
    logic [2:0] r_step;
    logic       r_rd;
    logic [6:0] r_dev;
    logic [7:0] r_regaddr;
    logic [7:0] r_wdata;
    logic       r_req_ready;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_twi_wr;
    logic [7:0] r_twi_addr;
    logic [7:0] r_twi_data;

    logic       w_accept;
    logic       w_done;
    logic [2:0] w_last;
    logic [2:0] w_step_nx;
    logic [7:0] w_cmd_cur;
    logic [7:0] w_cmd_nx;
    logic [7:0] w_byte_nx;
    logic       w_unused;

    assign w_accept  = bus.req_valid && r_req_ready;
    assign w_done    = bus.twi_i2cr[2];
    assign w_last    = r_rd ? 3'd6 : 3'd4;
    assign w_step_nx = r_step + 3'd1;
    assign w_cmd_cur = f_cmd(r_rd, r_step);
    assign w_cmd_nx  = f_cmd(r_rd, w_step_nx);
    assign w_byte_nx = f_byte(w_step_nx, r_dev, r_regaddr, r_wdata);
    assign w_unused  = ^{bus.twi_i2cr[7:3], bus.twi_i2cr[1:0]};

`ifdef TWI_SEQ_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_rsp_err;
    logic        w_timeout;

    // Fires so that the DIS write lands TIMEOUT_CYC cycles after the KICK cycle.
    assign w_timeout   = (r_wait_cnt == 16'(TIMEOUT_CYC - 2));
    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= 3'd0;
            r_rd        <= 1'b0;
            r_dev       <= 7'd0;
            r_regaddr   <= 8'h00;
            r_wdata     <= 8'h00;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_twi_wr    <= 1'b0;
            r_twi_addr  <= 8'h00;
            r_twi_data  <= 8'h00;
`ifdef TWI_SEQ_TIMEOUT_EN
            r_wait_cnt  <= 16'd0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_twi_wr    <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_RSP: begin
                    if (w_accept) begin
                        r_rd        <= bus.req_rd;
                        r_dev       <= bus.req_dev;
                        r_regaddr   <= bus.req_reg;
                        r_wdata     <= bus.req_wdata;
                        r_step      <= 3'd0;
                        r_req_ready <= 1'b0;
`ifdef TWI_SEQ_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_twi_wr    <= 1'b1;
                        r_twi_addr  <= ADDR_I2CR;
                        r_twi_data  <= CMD_START;
                        r_state     <= S_KICK;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_LDWD: begin
                    r_twi_wr   <= 1'b1;
                    r_twi_addr <= ADDR_I2CR;
                    r_twi_data <= w_cmd_cur;
                    r_state    <= S_KICK;
                end
                S_KICK: begin
`ifdef TWI_SEQ_TIMEOUT_EN
                    r_wait_cnt <= 16'd0;
`endif
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done) begin
                        if (w_cmd_cur == CMD_RD) begin
                            r_rsp_rdata <= bus.twi_i2rd;
                        end
                        r_twi_wr <= 1'b1;
                        if (r_step == w_last) begin
                            r_twi_addr <= ADDR_I2CR;
                            r_twi_data <= CMD_DIS;
                            r_state    <= S_DIS;
                        end else if (w_cmd_nx == CMD_WR) begin
                            r_step     <= w_step_nx;
                            r_twi_addr <= ADDR_I2WD;
                            r_twi_data <= w_byte_nx;
                            r_state    <= S_LDWD;
                        end else begin
                            r_step     <= w_step_nx;
                            r_twi_addr <= ADDR_I2CR;
                            r_twi_data <= w_cmd_nx;
                            r_state    <= S_KICK;
                        end
`ifdef TWI_SEQ_TIMEOUT_EN
                    end else if (w_timeout) begin
                        r_rsp_err  <= 1'b1;
                        r_twi_wr   <= 1'b1;
                        r_twi_addr <= ADDR_I2CR;
                        r_twi_data <= CMD_DIS;
                        r_state    <= S_DIS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
`endif
                    end
                end
                S_DIS: begin
                    r_rsp_valid <= 1'b1;
                    r_req_ready <= 1'b1;
                    r_state     <= S_RSP;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.twi_wr    = r_twi_wr;
    assign bus.twi_addr  = r_twi_addr;
    assign bus.twi_data  = r_twi_data;
endmodule

// File: tb/tb_twi_seq.sv
// tb/tb_twi_seq.sv - directed and random transactions against a twi_core model and expected command lists
module tb_twi_seq;
    localparam logic [7:0] I2CR = 8'h00;
    localparam logic [7:0] I2WD = 8'h01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    twi_seq_if bus();

`ifdef TWI_SEQ_TIMEOUT_EN
    twi_seq #(.TIMEOUT_CYC(100)) u_dut (.clk(clk), .rst(rst), .bus(bus));
`else
    twi_seq u_dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    logic [7:0] m_i2cr = 8'h00;
    logic [7:0] m_i2rd = 8'h00;
    logic       m_busy = 1'b0;
    logic       m_is_rd = 1'b0;
    int         m_lat = 0;
    logic       stall = 1'b0;
    logic [7:0] slave_byte = 8'h00;

    assign bus.twi_i2cr = m_i2cr;
    assign bus.twi_i2rd = m_i2rd;

    // twi_core stand-in: a command clears done, done returns after a random delay unless stalled
    always @(posedge clk) begin
        if (bus.twi_wr && bus.twi_addr == I2CR && bus.twi_data != 8'h00) begin
            m_i2cr  <= bus.twi_data;
            m_busy  <= 1'b1;
            m_is_rd <= (bus.twi_data == 8'h23);
            m_lat   <= int'($urandom_range(0, 4));
        end else if (m_busy && !stall) begin
            if (m_lat == 0) begin
                m_busy    <= 1'b0;
                m_i2cr[2] <= 1'b1;
                if (m_is_rd) m_i2rd <= slave_byte;
            end else begin
                m_lat <= m_lat - 1;
            end
        end
    end

    logic [15:0] wr_log[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          n_viol = 0;
    logic [7:0]  last_rdata = 8'h00;
    logic        last_err = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            if (bus.twi_wr) begin
                wr_log.push_back({bus.twi_addr, bus.twi_data});
                wr_cyc.push_back(cyc);
                if (bus.rsp_valid || bus.req_ready) n_viol++;
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
            end
        end
    end

    logic [15:0] exp_q[$];
    logic [7:0]  model_rdata = 8'h00;
    logic        acc_rsp;
    int          acc_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd);
        exp_q.push_back({I2CR, 8'h03});
        exp_q.push_back({I2WD, dev, 1'b0});
        exp_q.push_back({I2CR, 8'h13});
        exp_q.push_back({I2WD, ra});
        exp_q.push_back({I2CR, 8'h13});
        if (rd) begin
            exp_q.push_back({I2CR, 8'h03});
            exp_q.push_back({I2WD, dev, 1'b1});
            exp_q.push_back({I2CR, 8'h13});
            exp_q.push_back({I2CR, 8'h23});
            model_rdata = slave_byte;
        end else begin
            exp_q.push_back({I2WD, wd});
            exp_q.push_back({I2CR, 8'h13});
        end
        exp_q.push_back({I2CR, 8'h33});
        exp_q.push_back({I2CR, 8'h00});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size()) chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_q[i]);
        end
    endtask

    task automatic issue(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd);
        int n;
        bus.req_rd    = rd;
        bus.req_dev   = dev;
        bus.req_reg   = ra;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        acc_rsp = bus.rsp_valid;
        acc_cnt = rsp_cnt;
        chk("accept_bound", n < 3000, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_bound", n < 3000, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_txn(input string tag, input logic rd, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd, input logic [7:0] sb);
        int base;
        wr_log.delete();
        wr_cyc.delete();
        exp_q.delete();
        slave_byte = sb;
        build_exp(rd, dev, ra, wd);
        base = rsp_cnt;
        issue(rd, dev, ra, wd);
        wait_rsp(base + 1);
        check_log(tag);
        chk({tag, "_rsp_cnt"}, rsp_cnt, base + 1);
        chk({tag, "_err"}, last_err, 1'b0);
        chk({tag, "_rdata"}, last_rdata, model_rdata);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 8'h00);
        chk({tag, "_rsp_err"},   bus.rsp_err,   1'b0);
        chk({tag, "_twi_wr"},    bus.twi_wr,    1'b0);
        chk({tag, "_twi_addr"},  bus.twi_addr,  8'h00);
        chk({tag, "_twi_data"},  bus.twi_data,  8'h00);
    endtask

    initial begin
        int base;
        int n;
        logic       r_rd;
        logic [6:0] r_dev;
        logic [7:0] r_ra, r_wd, r_sb;

        bus.req_valid = 1'b0;
        bus.req_rd    = 1'b0;
        bus.req_dev   = 7'd0;
        bus.req_reg   = 8'h00;
        bus.req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("after_reset");

        run_txn("wr_48_01", 1'b0, 7'h48, 8'h01, 8'hA5, 8'h00);
        run_txn("rd_48_00", 1'b1, 7'h48, 8'h00, 8'h00, 8'h3C);
        run_txn("wr_keep",  1'b0, 7'h50, 8'h7E, 8'h11, 8'hEE);

        // request held valid across a transaction: second one only on/after the RSP cycle
        wr_log.delete();
        exp_q.delete();
        slave_byte = 8'h5A;
        build_exp(1'b0, 7'h48, 8'h02, 8'hC3);
        build_exp(1'b1, 7'h22, 8'h09, 8'h00);
        base = rsp_cnt;
        issue(1'b0, 7'h48, 8'h02, 8'hC3);
        issue(1'b1, 7'h22, 8'h09, 8'h00);
        chk("held_accept_in_rsp", acc_rsp, 1'b1);
        chk("held_rsp_before_accept", acc_cnt, base + 1);
        wait_rsp(base + 2);
        check_log("held");
        chk("held_rsp_cnt", rsp_cnt, base + 2);
        chk("held_rdata", last_rdata, 8'h5A);

        // async reset while waiting on the WR reg command
        wr_log.delete();
        base = rsp_cnt;
        issue(1'b0, 7'h48, 8'h10, 8'h77);
        n = 0;
        while (wr_log.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        stall = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_pre_len", wr_log.size(), 5);
        if (wr_log.size() == 5) chk("rst_pre_last", wr_log[4], {I2CR, 8'h13});
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        model_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_no_rsp", rsp_cnt, base);
        run_txn("wr_after_rst", 1'b0, 7'h31, 8'h44, 8'h99, 8'h00);

`ifdef TWI_SEQ_TIMEOUT_EN
        wr_log.delete();
        wr_cyc.delete();
        stall = 1'b1;
        base  = rsp_cnt;
        issue(1'b0, 7'h48, 8'h01, 8'hA5);
        wait_rsp(base + 1);
        stall = 1'b0;
        chk("to_len", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("to_dis", wr_log[1], {I2CR, 8'h00});
            chk("to_gap", wr_cyc[1] - wr_cyc[0], 100);
        end
        chk("to_err", last_err, 1'b1);
        chk("to_rdata", last_rdata, model_rdata);
        run_txn("after_to", 1'b1, 7'h0F, 8'h20, 8'h00, 8'h81);
`endif

        for (int k = 0; k < 8; k++) begin
            r_rd  = 1'($urandom_range(0, 1));
            r_dev = 7'($urandom);
            r_ra  = 8'($urandom);
            r_wd  = 8'($urandom);
            r_sb  = 8'($urandom);
            run_txn($sformatf("rnd%0d", k), r_rd, r_dev, r_ra, r_wd, r_sb);
        end

        chk("no_wr_in_idle_rsp", n_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule

// File: doc/twi_seq.md
Name: twi_seq

Overview:
- Transaction sequencer directly upstream of twi_core.
- Accepts one register-level I2C request (device, register, data, read/write) and expands it into the twi_core command sequence (START / WR / RD / STOP) through twi_core's register write port.
- Polls twi_core's done bit between commands and returns read data plus a completion pulse to the requester (mcu-side glue or the test/config engine).

Parameters:
- TIMEOUT_CYC, 16384: maximum cycles spent waiting for the done bit per command. Only used when TWI_SEQ_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer idle, can accept a request.
- req_rd  input  1  1 = register read, 0 = register write.
- req_dev  input  7  7-bit I2C device address.
- req_reg  input  8  device register address.
- req_wdata  input  8  write data (ignored for reads).
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read data, valid with rsp_valid.
- rsp_err  output  1  timeout abort flag, valid with rsp_valid.
- twi_wr  output  1  register write strobe to twi_core.
- twi_addr  output  8  register address to twi_core (I2CR / I2WD from twi_define.v).
- twi_data  output  8  register write data to twi_core.
- twi_i2cr  input  8  twi_core control/status (bit 2 = done).
- twi_i2rd  input  8  twi_core read buffer.

Behaviour:
- Reset values: req_ready=1; rsp_valid=0; rsp_rdata=0x00; rsp_err=0; twi_wr=0; twi_addr=0x00; twi_data=0x00.
- All outputs are registered.
- Handshake: a request is accepted on a cycle with req_valid && req_ready. Request fields are latched that cycle and req_ready drops on the next cycle. req_valid while req_ready=0 is ignored.
- Write transaction: 5 steps.
  - START
  - WR {dev,0}
  - WR reg
  - WR wdata
  - STOP
- Read transaction: 7 steps.
  - START
  - WR {dev,0}
  - WR reg
  - START (repeated start)
  - WR {dev,1}
  - RD
  - STOP
- I2CR command codes: START=0x03, WR=0x13, RD=0x23, STOP=0x33 (en=1, init=1, done=0, cmd in bits 6:4). Disable = 0x00.
- FSM states: IDLE, LDWD, KICK, WAIT, DIS, RSP.
- IDLE -> (accept) -> LDWD if step is WR, otherwise KICK.
- LDWD: one cycle with twi_wr=1, twi_addr=I2WD, twi_data=step byte -> KICK.
- KICK: one cycle with twi_wr=1, twi_addr=I2CR, twi_data=command code -> WAIT.
- WAIT: twi_wr=0. Sample twi_i2cr[2] from the first cycle after KICK.
  - On done=1 after an RD step, latch twi_i2rd into rsp_rdata.
  - On done=1 with steps remaining, advance step -> LDWD or KICK.
  - On done=1 after the last step -> DIS.
- DIS: one cycle write of 0x00 to I2CR (releases SCL/SDA) -> RSP.
- RSP: rsp_valid=1 for exactly one cycle; req_ready=1 on the same cycle -> IDLE.
- Step counter: 3 bits, 0..6; cleared on accept. No wrap (it is bounded by the transaction length).
- rsp_rdata holds its value until the next read completes. A write transaction leaves it unchanged.
- Minimum command overhead: 1 cycle (START/STOP/RD) or 2 cycles (WR) plus 1 poll cycle, excluding twi_core time.
- Reset mid-transaction: the FSM returns to IDLE immediately and any partial rsp_valid is suppressed. twi_core is not commanded; the next accepted request re-initialises it with START.
- twi_wr is never asserted in IDLE or RSP.

Optional Feature:
- Macro: TWI_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on every KICK and increments in WAIT.
  - When it reaches TIMEOUT_CYC with done still 0, go to DIS (0x00 write aborts twi_core), then RSP with rsp_err=1 and rsp_rdata unchanged.
  - rsp_err is cleared on the next accept.
- Not defined: WAIT waits indefinitely, no counter is instantiated, and rsp_err is tied to 0.

Test Plan:
- Write dev=0x48 reg=0x01 wdata=0xA5 with the twi_core model -> twi_wr sequence I2CR=0x03; I2WD=0x90, I2CR=0x13; I2WD=0x01, I2CR=0x13; I2WD=0xA5, I2CR=0x13; I2CR=0x33; I2CR=0x00. Then one rsp_valid with rsp_err=0.
- Read dev=0x48 reg=0x00 with the slave model returning 0x3C -> I2WD values 0x90, 0x00, 0x91. Two I2CR=0x03 writes, one 0x23, then 0x33, then 0x00. rsp_rdata=0x3C.
- req_valid held high during a transaction with a different dev -> ignored; exactly one rsp_valid per accepted request; the second request is accepted only on or after the RSP cycle.
- Async rst asserted in WAIT of the WR reg step -> all outputs at reset values within the same cycle. A new write after release starts with I2CR=0x03.
- With TWI_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, done held 0 -> I2CR=0x00 written 100 cycles after KICK, then rsp_valid=1, rsp_err=1.
- Back-to-back read then write -> rsp_rdata retains the read value after the write completes.
